// File: rtl/dmem_responder_if.sv
// Core-to-responder data-memory port: request fields driven by the core,
// completion fields driven by the responder.
// One request in flight at a time; ready gates acceptance, rvalid pulses once.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder over an internal word-addressed RAM.
// Latency: completion pulse WAIT_CYCLES+1 edges after acceptance (acceptance edge counted).
// Backpressure: ready only in IDLE; req must be held until it is seen with ready=1.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2   // 0..15, the wait counter is 4 bits
) (
  input  logic       clk,
  input  logic       reset,       // asynchronous, active low
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem [DEPTH];

  // Operands of the access about to be committed
  logic                acc_en;
  logic                acc_we;
  logic [ADDR_W+1:0]   acc_addr;
  logic [31:0]         acc_wdata;
  logic [3:0]          acc_be;
  logic [ADDR_W-1:0]   acc_idx;
  logic                acc_mis;
  logic                mem_wr;

  // Address bits above the RAM range alias and are deliberately dropped
  logic                unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[31:ADDR_W+2];

  // Access operands: live inputs when committing straight from IDLE, captured copy otherwise
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == S_IDLE) begin
      acc_we    = bus.we;
      acc_addr  = bus.addr[ADDR_W+1:0];
      acc_wdata = bus.wdata;
      acc_be    = bus.be;
    end
    acc_idx = acc_addr[ADDR_W+1:2];
    acc_mis = (acc_addr[1:0] != 2'b00);
  end

  // Next-state, capture and completion-data logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    acc_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr[ADDR_W+1:0];
          wdata_d = bus.wdata;
          be_d    = bus.be;
          if (WAIT_CYCLES == 0) begin
            acc_en  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          acc_en  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Misaligned accesses report an error and return zero; stores return zero
    if (acc_en) begin
      err_d   = acc_mis;
      rdata_d = (!acc_we && !acc_mis) ? mem[acc_idx] : 32'h0;
    end
  end

  assign mem_wr = acc_en && acc_we && !acc_mis;

  // Control and captured-request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM write port: byte-lane merge on committed aligned stores only
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.rvalid = (state_q == S_RESP);
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 2, 0, 3) on a shared request bus.
// Expected results come from a word-array model of the RAM and fixed vectors.
// Every wait on the DUT is bounded; timeouts count as failures.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();
  dmem_responder_if if2 ();

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  int          sel;
  logic        req_s, we_s;
  logic [31:0] addr_s, wdata_s;
  logic [3:0]  be_s;

  assign if0.req = req_s && (sel == 0);
  assign if1.req = req_s && (sel == 1);
  assign if2.req = req_s && (sel == 2);
  assign if0.we = we_s;     assign if1.we = we_s;     assign if2.we = we_s;
  assign if0.addr = addr_s; assign if1.addr = addr_s; assign if2.addr = addr_s;
  assign if0.wdata = wdata_s; assign if1.wdata = wdata_s; assign if2.wdata = wdata_s;
  assign if0.be = be_s;     assign if1.be = be_s;     assign if2.be = be_s;

  logic        ready_m, rvalid_m, err_m;
  logic [31:0] rdata_m;
  always_comb begin
    ready_m = if0.ready; rvalid_m = if0.rvalid; rdata_m = if0.rdata; err_m = if0.err;
    case (sel)
      1: begin ready_m = if1.ready; rvalid_m = if1.rvalid; rdata_m = if1.rdata; err_m = if1.err; end
      2: begin ready_m = if2.ready; rvalid_m = if2.rvalid; rdata_m = if2.rdata; err_m = if2.err; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int wait_of(input int s);
    case (s)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // Reference RAM contents per instance (1024 words each)
  logic [31:0] mm [3][1024];

  task automatic model_txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, output logic [31:0] erd, output logic ee);
    int idx;
    idx = int'(a[11:2]);
    erd = 32'h0;
    ee  = 1'b0;
    if (a[1:0] != 2'b00) ee = 1'b1;
    else if (w) begin
      for (int j = 0; j < 4; j++)
        if (b[j]) mm[s][idx][8*j +: 8] = d[8*j +: 8];
    end else erd = mm[s][idx];
  endtask

  // Drive one request on the selected instance, return completion data and latency
  task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                         output logic [31:0] rd, output logic e, output int lat, output bit ok);
    int n;
    ok = 1'b0; rd = '0; e = 1'b0; lat = -1;
    @(negedge clk);
    req_s = 1'b1; we_s = w; addr_s = a; wdata_s = d; be_s = b;
    n = 0;
    while (!ready_m && n < 20) begin @(negedge clk); n++; end
    if (!ready_m) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_s = 1'b0;
      return;
    end
    @(negedge clk);
    // Scramble the request fields so only the captured copy can be used
    req_s = 1'b0; we_s = 1'($urandom); addr_s = $urandom; wdata_s = $urandom; be_s = 4'($urandom);
    lat = 0;
    while (!rvalid_m && lat < 40) begin @(negedge clk); lat++; end
    if (!rvalid_m) begin
      check("rvalid_timeout", 32'd0, 32'd1);
      return;
    end
    rd = rdata_m;
    e  = err_m;
    check("ready_low_in_resp", 32'(ready_m), 32'd0);
    @(negedge clk);
    check("rvalid_one_cycle", 32'(rvalid_m), 32'd0);
    check("rdata_cleared", rdata_m, 32'h0);
    ok = 1'b1;
  endtask

  task automatic do_txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    logic [31:0] erd, rd;
    logic        ee, e;
    int          lat;
    bit          ok;
    sel = s;
    model_txn(s, w, a, d, b, erd, ee);
    run_txn(w, a, d, b, rd, e, lat, ok);
    if (ok) begin
      check($sformatf("latency_i%0d", s), 32'(lat), 32'(wait_of(s)));
      check($sformatf("rdata_i%0d_a%h", s, a), rd, erd);
      check($sformatf("err_i%0d_a%h", s, a), 32'(e), 32'(ee));
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vt [10];
  logic [31:0] erd, rd, a, bb_addr [4];
  logic        ee, e;
  int          lat, nacc, ncomp, nrv;
  bit          ok;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
    vt[1] = '{1'b0, 32'h10,   32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
    vt[2] = '{1'b1, 32'h20,   32'h11223344, 4'b1111, 32'h0,        1'b0};
    vt[3] = '{1'b1, 32'h20,   32'hAABBCCDD, 4'b0101, 32'h0,        1'b0};
    vt[4] = '{1'b0, 32'h20,   32'h0,        4'b1111, 32'h11BB33DD, 1'b0};
    vt[5] = '{1'b1, 32'h22,   32'h12345678, 4'b1111, 32'h0,        1'b1};
    vt[6] = '{1'b0, 32'h20,   32'h0,        4'b0000, 32'h11BB33DD, 1'b0};
    vt[7] = '{1'b1, 32'h1004, 32'h00000005, 4'b1111, 32'h0,        1'b0};
    vt[8] = '{1'b0, 32'h0004, 32'h0,        4'b0000, 32'h00000005, 1'b0};
    vt[9] = '{1'b0, 32'h21,   32'h0,        4'b0000, 32'h0,        1'b1};

    sel = 0; req_s = 1'b0; we_s = 1'b0; addr_s = '0; wdata_s = '0; be_s = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check($sformatf("rst_ready_i%0d", s), 32'(ready_m), 32'd1);
      check($sformatf("rst_rvalid_i%0d", s), 32'(rvalid_m), 32'd0);
      check($sformatf("rst_rdata_i%0d", s), rdata_m, 32'h0);
      check($sformatf("rst_err_i%0d", s), 32'(err_m), 32'd0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        sel = s; #1;
        check($sformatf("idle_ready_i%0d", s), 32'(ready_m), 32'd1);
        check($sformatf("idle_rvalid_i%0d", s), 32'(rvalid_m), 32'd0);
        check($sformatf("idle_rdata_i%0d", s), rdata_m, 32'h0);
        check($sformatf("idle_err_i%0d", s), 32'(err_m), 32'd0);
      end
    end

    // Give words 0..15 of every instance defined contents
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 16; w++)
        do_txn(s, 1'b1, 32'(w * 4), $urandom, 4'b1111);

    // Fixed vectors on the WAIT_CYCLES=2 instance
    for (int i = 0; i < 10; i++) begin
      sel = 0;
      model_txn(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, erd, ee);
      run_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, e, lat, ok);
      if (ok) begin
        check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
        check($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
        check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        check($sformatf("vec%0d_model", i), vt[i].exp_rdata, erd);
      end
    end

    // Back-to-back loads with req held, WAIT_CYCLES=0
    bb_addr[0] = 32'h0; bb_addr[1] = 32'h8; bb_addr[2] = 32'h1004; bb_addr[3] = 32'h3C;
    sel = 1; nacc = 0; ncomp = 0;
    @(negedge clk);
    req_s = 1'b1; we_s = 1'b0; addr_s = bb_addr[0]; be_s = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("b2b_ready_c%0d", c), 32'(ready_m), 32'((c % 2) == 0));
      check($sformatf("b2b_rvalid_c%0d", c), 32'(rvalid_m), 32'((c % 2) == 1));
      if (rvalid_m && ncomp < 4) begin
        a = bb_addr[ncomp];
        check($sformatf("b2b_rdata_%0d", ncomp), rdata_m, mm[1][a[11:2]]);
        ncomp++;
      end
      if (ready_m && req_s) nacc++;
      @(negedge clk);
      if (nacc < 4) addr_s = bb_addr[nacc];
      else req_s = 1'b0;
    end
    check("b2b_completions", 32'(ncomp), 32'd4);

    // Randomised mix across all instances, including aliasing and misalignment
    for (int i = 0; i < 150; i++) begin
      a = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_txn($urandom_range(0, 2), 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Reset during the wait states of a store: the store must never land
    do_txn(2, 1'b1, 32'h30, 32'h0, 4'b1111);
    sel = 2;
    @(negedge clk);
    req_s = 1'b1; we_s = 1'b1; addr_s = 32'h30; wdata_s = 32'hCAFEF00D; be_s = 4'b1111;
    check("abort_ready_before", 32'(ready_m), 32'd1);
    @(negedge clk);
    req_s = 1'b0;
    check("abort_ready_in_wait", 32'(ready_m), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nrv = 0;
    #1;
    check("abort_ready_in_reset", 32'(ready_m), 32'd1);
    repeat (2) begin @(negedge clk); if (rvalid_m) nrv++; end
    reset = 1'b1;
    repeat (8) begin @(negedge clk); if (rvalid_m) nrv++; end
    check("abort_no_rvalid", 32'(nrv), 32'd0);
    sel = 2;
    run_txn(1'b0, 32'h30, 32'h0, 4'b0000, rd, e, lat, ok);
    if (ok) begin
      check("abort_load_rdata", rd, 32'h0);
      check("abort_load_err", 32'(e), 32'd0);
      check("abort_load_latency", 32'(lat), 32'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
